// File: rtl/dc_pkg.sv
// Shared definitions for the digital clock: setting-mode encoding and
// default timing constants used by the set controller and the time datapath.
package dc_pkg;

  // Controller state, also driven out as the 2-bit mode code (3 unused).
  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2
  } mode_e;

  localparam int unsigned TICK_DIV_DEF   = 50_000_000;  // clk_50 cycles per second
  localparam int unsigned REPEAT_CYC_DEF = 25_000_000;  // hold delay / auto-repeat period
  localparam int unsigned CNT_W          = 32;          // prescaler and timer width

endpackage

// File: rtl/btn_sync_edge.sv
// Button conditioner: 2-flop synchronizer plus registered rising-edge pulse.
// A button already high when reset releases stays disarmed until it has
// been seen low, so a held button never fakes an edge.
//   i_clk      clock
//   i_rst_n    asynchronous active-low reset
//   i_btn      debounced button level, asynchronous to i_clk
//   o_rise     one-cycle pulse, two cycles after the level is first sampled
//   o_level_c  synchronized (and armed) button level
module btn_sync_edge (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_rise,
  output logic o_level_c
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;
  logic r_vld1;
  logic r_vld2;
  logic r_armed;
  logic r_rise;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
      r_vld1  <= 1'b0;
      r_vld2  <= 1'b0;
      r_armed <= 1'b0;
      r_rise  <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      // r_vld2 marks r_sync2 as holding a real sample rather than reset zeros
      r_vld1  <= 1'b1;
      r_vld2  <= r_vld1;
      if (r_vld2 && !r_sync2) begin
        r_armed <= 1'b1;
      end
      r_rise  <= r_armed && r_sync2 && !r_prev;
    end
  end

  assign o_rise    = r_rise;
  assign o_level_c = r_armed && r_sync2;

endmodule

// File: rtl/clock_set_ctrl.sv
// Digital clock set controller: second prescaler, RUN/SET_HR/SET_MIN mode
// FSM, increment pulses with auto-repeat, and field blink enable.
//   clk_50      sole clock
//   reset       asynchronous active-low reset
//   btn_mode    mode button level (asynchronous)
//   btn_inc     increment button level (asynchronous)
//   sec_tick    one-cycle pulse: advance seconds
//   min_inc     one-cycle pulse: increment minutes
//   hr_inc      one-cycle pulse: increment hours
//   sec_clr     one-cycle pulse: clear seconds
//   mode        0=RUN, 1=SET_HR, 2=SET_MIN
//   blink       blink enable for the field being set
module clock_set_ctrl
  import dc_pkg::*;
#(
  parameter int unsigned TICK_DIV   = TICK_DIV_DEF,
  parameter int unsigned REPEAT_CYC = REPEAT_CYC_DEF
) (
  input  logic       clk_50,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic       sec_tick,
  output logic       min_inc,
  output logic       hr_inc,
  output logic       sec_clr,
  output logic [1:0] mode,
  output logic       blink
);

  localparam logic [CNT_W-1:0] TICK_LAST  = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(TICK_DIV / 4 - 1);
  localparam logic [CNT_W-1:0] REP_LAST   = CNT_W'(REPEAT_CYC - 1);

  logic             w_mode_p;
  logic             w_mode_lvl;
  logic             w_inc_p;
  logic             w_inc_lvl;
  logic             w_rep_hit;
  logic             w_inc_fire;

  mode_e            r_mode;
  logic [CNT_W-1:0] r_presc;
  logic [CNT_W-1:0] r_blink_cnt;
  logic [CNT_W-1:0] r_rep;
  logic             r_rep_act;
  logic             r_sec_tick;
  logic             r_min_inc;
  logic             r_hr_inc;
  logic             r_sec_clr;
  logic             r_blink;

  btn_sync_edge u_mode_btn (
    .i_clk     (clk_50),
    .i_rst_n   (reset),
    .i_btn     (btn_mode),
    .o_rise    (w_mode_p),
    .o_level_c (w_mode_lvl)
  );

  btn_sync_edge u_inc_btn (
    .i_clk     (clk_50),
    .i_rst_n   (reset),
    .i_btn     (btn_inc),
    .o_rise    (w_inc_p),
    .o_level_c (w_inc_lvl)
  );

  // Increment request this cycle: fresh press or an auto-repeat interval expiring
  always_comb begin
    w_rep_hit  = r_rep_act && w_inc_lvl && (r_rep == REP_LAST);
    w_inc_fire = w_inc_p || w_rep_hit;
  end

  // Auto-repeat timer: armed by a press in a SET state, cleared by release,
  // RUN, or any mode change (so nothing carries into the next state)
  always_ff @(posedge clk_50 or negedge reset) begin
    if (!reset) begin
      r_rep     <= '0;
      r_rep_act <= 1'b0;
    end else if (r_mode == RUN || w_mode_p || !w_inc_lvl) begin
      r_rep     <= '0;
      r_rep_act <= 1'b0;
    end else if (w_inc_p) begin
      r_rep     <= '0;
      r_rep_act <= 1'b1;
    end else if (r_rep_act) begin
      r_rep     <= w_rep_hit ? '0 : r_rep + CNT_W'(1);
    end
  end

  // Mode FSM with prescaler, blink timer and registered pulse outputs
  always_ff @(posedge clk_50 or negedge reset) begin
    if (!reset) begin
      r_mode      <= RUN;
      r_presc     <= '0;
      r_blink_cnt <= '0;
      r_sec_tick  <= 1'b0;
      r_min_inc   <= 1'b0;
      r_hr_inc    <= 1'b0;
      r_sec_clr   <= 1'b0;
      r_blink     <= 1'b0;
    end else begin
      r_sec_tick <= 1'b0;
      r_min_inc  <= 1'b0;
      r_hr_inc   <= 1'b0;
      r_sec_clr  <= 1'b0;
      case (r_mode)
        RUN: begin
          r_blink     <= 1'b0;
          r_blink_cnt <= '0;
          if (w_mode_p) begin
            // freeze time: prescaler parks at 0 until the next RUN entry
            r_mode  <= SET_HR;
            r_presc <= '0;
            r_blink <= 1'b1;
          end else if (r_presc == TICK_LAST) begin
            r_presc    <= '0;
            r_sec_tick <= 1'b1;
          end else begin
            r_presc <= r_presc + CNT_W'(1);
          end
        end
        SET_HR: begin
          if (w_mode_p) begin
            r_mode      <= SET_MIN;
            r_blink     <= 1'b1;
            r_blink_cnt <= '0;
          end else begin
            r_hr_inc <= w_inc_fire;
            if (r_blink_cnt == BLINK_LAST) begin
              r_blink_cnt <= '0;
              r_blink     <= ~r_blink;
            end else begin
              r_blink_cnt <= r_blink_cnt + CNT_W'(1);
            end
          end
        end
        SET_MIN: begin
          if (w_mode_p) begin
            r_mode      <= RUN;
            r_sec_clr   <= 1'b1;
            r_presc     <= '0;
            r_blink     <= 1'b0;
            r_blink_cnt <= '0;
          end else begin
            r_min_inc <= w_inc_fire;
            if (r_blink_cnt == BLINK_LAST) begin
              r_blink_cnt <= '0;
              r_blink     <= ~r_blink;
            end else begin
              r_blink_cnt <= r_blink_cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          r_mode <= RUN;
        end
      endcase
    end
  end

  assign sec_tick = r_sec_tick;
  assign min_inc  = r_min_inc;
  assign hr_inc   = r_hr_inc;
  assign sec_clr  = r_sec_clr;
  assign mode     = r_mode;
  assign blink    = r_blink;

endmodule
